// File: rtl/mac_mul_pipe.sv
// mac_mul_pipe: 2-stage handshaked signed/unsigned sub-word multiplier
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   en                   global enable; 0 freezes all state and drops in_ready
//   in_valid / in_ready  operand handshake (cfg, A, B)
//   cfg                  [1:0] mode (0 SINGLE, 1 DUAL, 2 QUAD, 3 reserved), [2] signed
//   A                    four W-bit lanes, A0 in the LSBs
//   B                    W-bit multiplier lane
//   out_valid/out_ready  result handshake (C, out_cfg)
//   C                    registered product, sign/zero-extended to MAC_INT_WIDTH
//   out_cfg              cfg of the transaction held in C
module mac_mul_pipe #(
  parameter int MAC_CONF_WIDTH = 3,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
  parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MAC_CONF_WIDTH-1:0]  cfg,
  input  logic [4*MAC_MIN_WIDTH-1:0] A,
  input  logic [MAC_MIN_WIDTH-1:0]   B,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MAC_INT_WIDTH-1:0]   C,
  output logic [MAC_CONF_WIDTH-1:0]  out_cfg
);
  localparam int W  = MAC_MIN_WIDTH;
  localparam int PW = MAC_MULT_WIDTH + 1;
  localparam logic [1:0] MAC_SINGLE = 2'd0;
  localparam logic [1:0] MAC_DUAL   = 2'd1;
  localparam logic [1:0] MAC_QUAD   = 2'd2;

  logic                      r_v1, r_v2;
  logic [MAC_CONF_WIDTH-1:0] r_cfg1, r_cfg2;
  logic [PW-1:0]             r_p [4];
  logic [MAC_INT_WIDTH-1:0]  r_c;
  logic [PW-1:0]             w_pp [4];
  logic [MAC_INT_WIDTH-1:0]  w_ext [4];
  logic [MAC_INT_WIDTH-1:0]  w_res;
  logic signed [W:0]         w_b;
  logic                      w_s1_ld, w_s2_ld;

  assign w_s2_ld   = !r_v2 || out_ready;
  assign w_s1_ld   = !r_v1 || w_s2_ld;
  assign in_ready  = en && !rst && w_s1_ld;
  assign out_valid = r_v2;
  assign C         = r_c;
  assign out_cfg   = r_cfg2;
  assign w_b       = {cfg[2] & B[W-1], B};

  // Only the most significant active lane carries the sign of A: lane 2 in
  // SINGLE, lane 3 in DUAL/QUAD; all other lanes are unsigned magnitudes.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic              w_sgn;
    logic signed [W:0] w_a;
    logic signed [2*W+1:0] w_full;
    assign w_sgn  = cfg[2] && ((i == 3) ? cfg[1:0] != MAC_SINGLE : (i == 2) ? cfg[1:0] == MAC_SINGLE : 1'b0);
    assign w_a    = {w_sgn & A[i*W+W-1], A[i*W +: W]};
    assign w_full = w_a * w_b;
    assign w_pp[i]  = w_full[PW-1:0];
    assign w_ext[i] = {{(MAC_INT_WIDTH-PW){r_p[i][PW-1]}}, r_p[i]};
  end

  always_comb begin
    w_res = r_cfg1[1:0] == MAC_SINGLE ? w_ext[2] :
            r_cfg1[1:0] == MAC_DUAL   ? w_ext[2] + (w_ext[3] << W) :
            r_cfg1[1:0] == MAC_QUAD   ? w_ext[0] + (w_ext[1] << W) + (w_ext[2] << 2*W) + (w_ext[3] << 3*W) :
            '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_c    <= '0;
      r_cfg2 <= '0;
    end else if (en) begin
      if (w_s1_ld) begin
        r_v1   <= in_valid;
        r_cfg1 <= cfg;
        r_p    <= w_pp;
      end
      if (w_s2_ld) begin
        r_v2   <= r_v1;
        r_c    <= w_res;
        r_cfg2 <= r_cfg1;
      end
    end
  end
endmodule

// File: tb/tb_mac_mul_pipe.sv
// tb_mac_mul_pipe: directed and randomized scoreboard bench for mac_mul_pipe
module tb_mac_mul_pipe;
  localparam logic [2:0] U_SGL = 3'b000, U_DUAL = 3'b001, U_QUAD = 3'b010;
  localparam logic [2:0] S_SGL = 3'b100, S_QUAD = 3'b110;

  typedef struct packed {logic [39:0] c; logic [2:0] f;} exp_t;

  logic        clk = 0, rst = 1, en = 1, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [2:0]  cfg = 0, out_cfg;
  logic [31:0] A = 0;
  logic [7:0]  B = 0;
  logic [39:0] C;

  int n_chk = 0, n_err = 0;
  exp_t q[$];
  logic        p_hold = 0, p_ov;
  logic [39:0] p_c;
  logic [2:0]  p_cfg;

  mac_mul_pipe dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .cfg(cfg), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .out_cfg(out_cfg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask

  // Reference: the active lanes form one operand (A2, A3:A2 or A3..A0),
  // interpreted as two's complement when signed, times B.
  function automatic logic [39:0] model(input logic [2:0] c, input logic [31:0] a, input logic [7:0] b);
    longint av, bv;
    bv = c[2] ? longint'($signed(b)) : longint'(b);
    case (c[1:0])
      2'd0:    av = c[2] ? longint'($signed(a[23:16])) : longint'(a[23:16]);
      2'd1:    av = c[2] ? longint'($signed(a[31:16])) : longint'(a[31:16]);
      2'd2:    av = c[2] ? longint'($signed(a)) : longint'(a);
      default: return 40'd0;
    endcase
    return 40'(av * bv);
  endfunction

  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (p_hold) begin
        chk("hold_v", out_valid, p_ov);
        chk("hold_c", C, p_c);
        chk("hold_cfg", out_cfg, p_cfg);
      end
      if (!en) chk("en_rdy", in_ready, 0);
      if (out_valid && out_ready && en) begin
        if (q.size() == 0) chk("sb_extra_out", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_c", C, e.c);
          chk("sb_cfg", out_cfg, e.f);
        end
      end
      if (in_valid && in_ready) q.push_back('{model(cfg, A, B), cfg});
    end
    p_hold = !rst && (!en || (out_valid && !out_ready));
    p_ov = out_valid;
    p_c = C;
    p_cfg = out_cfg;
  end

  task automatic one(input logic [2:0] c, input logic [31:0] a, input logic [7:0] b, input logic [39:0] e, input string t);
    out_ready = 1; cfg = c; A = a; B = b; in_valid = 1;
    @(negedge clk) chk({t, "_rdy"}, in_ready, 1);
    @(posedge clk) #1 in_valid = 0;
    @(negedge clk) chk({t, "_lat1"}, out_valid, 0);
    @(negedge clk) begin
      chk({t, "_lat2"}, out_valid, 1);
      chk(t, C, e);
    end
    @(posedge clk) #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] hist[16];
    int acc, k;
    logic rdy;
    @(negedge clk) chk("rst_in_ready", in_ready, 0);
    @(posedge clk) #1 rst = 0;
    @(negedge clk) begin
      chk("rst_ov", out_valid, 0);
      chk("rst_c", C, 0);
      chk("rst_cfg", out_cfg, 0);
    end
    @(posedge clk) #1;
    one(U_SGL,  32'h00FF_0000, 8'hFF, 40'h00_0000_FE01, "u_single");
    one(S_SGL,  32'h00FF_0000, 8'h02, 40'hFF_FFFF_FFFE, "s_single");
    one(U_DUAL, 32'hFFFF_0000, 8'hFF, 40'h00_00FE_FF01, "u_dual");
    one(U_QUAD, 32'hFFFF_FFFF, 8'hFF, 40'hFE_FFFF_FF01, "u_quad");
    one(S_QUAD, 32'h8000_0000, 8'h7F, 40'hC0_8000_0000, "s_quad");
    one(3'b011, 32'hFFFF_FFFF, 8'hFF, 40'h0, "reserved");

    // backpressure: 4 SINGLE transactions, consumer stalled for 5 cycles
    out_ready = 0; cfg = U_SGL; B = 1; A = 32'h0001_0000; in_valid = 1; acc = 0; k = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk) begin
        rdy = in_ready;
        if (c >= 2) begin chk("bp_stall_v", out_valid, 1); chk("bp_stall_c", C, 1); end
      end
      @(posedge clk) #1;
      if (rdy) begin acc++; k++; if (k <= 4) A = 32'(k) << 16; else in_valid = 0; end
    end
    chk("bp_accepts", acc, 2);
    out_ready = 1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk) begin chk("bp_nogap", out_valid, 1); chk("bp_order", C, j + 1); rdy = in_ready; end
      @(posedge clk) #1;
      if (rdy && in_valid) begin k++; if (k <= 4) A = 32'(k) << 16; else in_valid = 0; end
    end
    @(negedge clk) chk("bp_drain", out_valid, 0);
    @(posedge clk) #1;

    // mixed cfg streaming
    for (int j = 0; j < 16; j++) begin
      cfg = j[0] ? S_QUAD : S_SGL; hist[j] = cfg; A = $urandom; B = 8'($urandom); in_valid = 1;
      @(negedge clk) if (j >= 2) chk("mix_cfg_d2", out_cfg, hist[j-2]);
      @(posedge clk) #1;
    end
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;

    // en low for 3 cycles mid-stream
    for (int j = 0; j < 14; j++) begin
      en = !(j >= 5 && j < 8); cfg = 3'($urandom); A = $urandom; B = 8'($urandom); in_valid = 1;
      @(posedge clk) #1;
    end
    en = 1; in_valid = 0;
    repeat (3) @(posedge clk);
    #1;

    // reset with both stages full and consumer stalled
    out_ready = 0; cfg = U_SGL; A = 32'h0005_0000; B = 3; in_valid = 1;
    repeat (2) @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk) chk("mr_full", out_valid, 1);
    @(posedge clk) #1 rst = 1;
    @(negedge clk) chk("mr_rdy", in_ready, 0);
    @(posedge clk) #1 rst = 0;
    @(negedge clk) begin chk("mr_ov", out_valid, 0); chk("mr_c", C, 0); end
    @(posedge clk) #1;
    one(U_SGL, 32'h0007_0000, 8'h09, 40'd63, "mr_post");

    // randomized traffic
    for (int j = 0; j < 1500; j++) begin
      in_valid = ($urandom % 4) != 0; out_ready = ($urandom % 3) != 0; en = ($urandom % 8) != 0;
      cfg = 3'($urandom); A = $urandom; B = 8'($urandom);
      @(posedge clk) #1;
    end
    in_valid = 0; out_ready = 1; en = 1;
    repeat (4) @(posedge clk);
    @(negedge clk) chk("final_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
